// File: rtl/aibcr3aux_por_seq.sv
// Power-on / device-detect reset sequencer: synchronizes and debounces AUX POR and device
// detect, then releases the per-channel resets one at a time to limit wake-up in-rush.
module aibcr3aux_por_seq #(
    parameter int unsigned NCH         = 24,
    parameter int unsigned DEB_CYC     = 16,
    parameter int unsigned STAGGER_CYC = 4
) (
    input  logic           i_osc_clk,
    input  logic           i_rst_n,
    input  logic           i_por_vcchssi,
    input  logic           i_device_detect,
    output logic [NCH-1:0] o_chan_rst_n,
    output logic           o_aux_rdy,
    output logic [1:0]     o_seq_state
);

    localparam int unsigned IdxW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [7:0]      DebMax  = 8'(DEB_CYC - 1);
    localparam logic [7:0]      StagMax = 8'(STAGGER_CYC - 1);
    localparam logic [IdxW-1:0] IdxMax  = IdxW'(NCH - 1);
    localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StWaitPwr = 2'b01,
        StRelease = 2'b10,
        StReady   = 2'b11
    } state_e;

    logic            por_meta_q, por_meta_d;
    logic            por_s_q, por_s_d;
    logic            dd_meta_q, dd_meta_d;
    logic            dd_s_q, dd_s_d;
    logic [7:0]      deb_cnt_q, deb_cnt_d;
    logic [7:0]      scnt_q, scnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [NCH-1:0]  chan_rst_n_q, chan_rst_n_d;
    logic            aux_rdy_q, aux_rdy_d;
    state_e          state_q, state_d;
    logic            qual;

    always_comb begin
        por_meta_d   = i_por_vcchssi;
        por_s_d      = por_meta_q;
        dd_meta_d    = i_device_detect;
        dd_s_d       = dd_meta_q;

        qual         = !por_s_q && dd_s_q;

        // Debounce only filters release; any unqualified cycle restarts it.
        if (!qual) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DebMax) begin
            deb_cnt_d = deb_cnt_q;
        end else begin
            deb_cnt_d = deb_cnt_q + 8'd1;
        end

        state_d      = state_q;
        idx_d        = idx_q;
        scnt_d       = scnt_q;
        chan_rst_n_d = chan_rst_n_q;
        aux_rdy_d    = aux_rdy_q;

        case (state_q)
            StIdle: begin
                state_d = StWaitPwr;
            end
            StWaitPwr: begin
                if (qual && (deb_cnt_q == DebMax)) begin
                    state_d = StRelease;
                    idx_d   = '0;
                    scnt_d  = '0;
                end
            end
            StRelease: begin
                if (scnt_q == StagMax) begin
                    chan_rst_n_d[idx_q] = 1'b1;
                    scnt_d              = '0;
                    // idx parks at the last channel so it never wraps.
                    if (idx_q == IdxMax) begin
                        state_d   = StReady;
                        aux_rdy_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxOne;
                    end
                end else begin
                    scnt_d = scnt_q + 8'd1;
                end
            end
            StReady: begin
                chan_rst_n_d = '1;
                aux_rdy_d    = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything above, including a release due on this edge.
        if ((state_q != StIdle) && !qual) begin
            state_d      = StWaitPwr;
            chan_rst_n_d = '0;
            aux_rdy_d    = 1'b0;
            idx_d        = '0;
            scnt_d       = '0;
        end
    end

    always_ff @(posedge i_osc_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            por_meta_q   <= 1'b1;
            por_s_q      <= 1'b1;
            dd_meta_q    <= 1'b0;
            dd_s_q       <= 1'b0;
            deb_cnt_q    <= '0;
            scnt_q       <= '0;
            idx_q        <= '0;
            chan_rst_n_q <= '0;
            aux_rdy_q    <= 1'b0;
            state_q      <= StIdle;
        end else begin
            por_meta_q   <= por_meta_d;
            por_s_q      <= por_s_d;
            dd_meta_q    <= dd_meta_d;
            dd_s_q       <= dd_s_d;
            deb_cnt_q    <= deb_cnt_d;
            scnt_q       <= scnt_d;
            idx_q        <= idx_d;
            chan_rst_n_q <= chan_rst_n_d;
            aux_rdy_q    <= aux_rdy_d;
            state_q      <= state_d;
        end
    end

    assign o_chan_rst_n = chan_rst_n_q;
    assign o_aux_rdy    = aux_rdy_q;
    assign o_seq_state  = state_q;

endmodule

// File: tb/tb_aibcr3aux_por_seq.sv
// Bench for aibcr3aux_por_seq: a default-parameter instance and a small (4/2/1) instance, each
// compared every cycle against a run-length model of the release rules plus directed timing checks.
module tb_aibcr3aux_por_seq;

    localparam int MNCH = 24, MDEB = 16, MSTAG = 4;
    localparam int SNCH = 4,  SDEB = 2,  SSTAG = 1;

    int checks = 0;
    int errors = 0;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic            m_rst_n, m_por, m_dd, m_rdy;
    logic [MNCH-1:0] m_chan;
    logic [1:0]      m_state;
    logic            s_rst_n, s_por, s_dd, s_rdy;
    logic [SNCH-1:0] s_chan;
    logic [1:0]      s_state;

    aibcr3aux_por_seq dut_m (
        .i_osc_clk      (clk),
        .i_rst_n        (m_rst_n),
        .i_por_vcchssi  (m_por),
        .i_device_detect(m_dd),
        .o_chan_rst_n   (m_chan),
        .o_aux_rdy      (m_rdy),
        .o_seq_state    (m_state)
    );

    aibcr3aux_por_seq #(
        .NCH        (SNCH),
        .DEB_CYC    (SDEB),
        .STAGGER_CYC(SSTAG)
    ) dut_s (
        .i_osc_clk      (clk),
        .i_rst_n        (s_rst_n),
        .i_por_vcchssi  (s_por),
        .i_device_detect(s_dd),
        .o_chan_rst_n   (s_chan),
        .o_aux_rdy      (s_rdy),
        .o_seq_state    (s_state)
    );

    // Model: input pins are seen two edges late; 'run' counts consecutive qualified edges.
    // Everything observable is a closed-form function of run.
    logic mh1p, mh1d, mh2p, mh2d, sh1p, sh1d, sh2p, sh2d;
    int   m_run, s_run;
    bit   m_started, s_started;

    always @(posedge clk or negedge m_rst_n) begin
        if (!m_rst_n) begin
            mh1p <= 1'b1; mh1d <= 1'b0; mh2p <= 1'b1; mh2d <= 1'b0;
            m_run <= 0; m_started <= 1'b0;
        end else begin
            m_started <= 1'b1;
            mh1p <= m_por; mh1d <= m_dd; mh2p <= mh1p; mh2d <= mh1d;
            m_run <= (!mh2p && mh2d) ? ((m_run < 100000) ? m_run + 1 : m_run) : 0;
        end
    end

    always @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sh1p <= 1'b1; sh1d <= 1'b0; sh2p <= 1'b1; sh2d <= 1'b0;
            s_run <= 0; s_started <= 1'b0;
        end else begin
            s_started <= 1'b1;
            sh1p <= s_por; sh1d <= s_dd; sh2p <= sh1p; sh2d <= sh1d;
            s_run <= (!sh2p && sh2d) ? ((s_run < 100000) ? s_run + 1 : s_run) : 0;
        end
    end

    function automatic int n_released(int run, int nch, int deb, int stag);
        int n;
        if (run < deb) return 0;
        n = (run - deb) / stag;
        return (n > nch) ? nch : n;
    endfunction

    function automatic logic [1:0] exp_state(bit started, int run, int nch, int deb, int stag);
        if (!started) return 2'b00;
        if (run < deb) return 2'b01;
        if (n_released(run, nch, deb, stag) < nch) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [31:0] exp_mask(int run, int nch, int deb, int stag);
        int rel;
        rel = n_released(run, nch, deb, stag);
        return (rel >= 32) ? 32'hFFFF_FFFF : ((32'd1 << rel) - 32'd1);
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_models(input string tag);
        cmp({tag, ":m_chan"}, 32'(m_chan), exp_mask(m_run, MNCH, MDEB, MSTAG));
        cmp({tag, ":m_rdy"}, 32'(m_rdy),
            32'(m_started && (n_released(m_run, MNCH, MDEB, MSTAG) == MNCH)));
        cmp({tag, ":m_state"}, 32'(m_state), 32'(exp_state(m_started, m_run, MNCH, MDEB, MSTAG)));
        cmp({tag, ":s_chan"}, 32'(s_chan), exp_mask(s_run, SNCH, SDEB, SSTAG));
        cmp({tag, ":s_rdy"}, 32'(s_rdy),
            32'(s_started && (n_released(s_run, SNCH, SDEB, SSTAG) == SNCH)));
        cmp({tag, ":s_state"}, 32'(s_state), 32'(exp_state(s_started, s_run, SNCH, SDEB, SSTAG)));
    endtask

    task automatic cyc(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            check_models(tag);
        end
    endtask

    initial begin
        int g;
        int h;
        m_rst_n = 1'b0; m_por = 1'b1; m_dd = 1'b0;
        s_rst_n = 1'b0; s_por = 1'b1; s_dd = 1'b0;
        cyc(2, "reset");
        cmp("reset:state", 32'(m_state), 32'd0);
        cmp("reset:chan", 32'(m_chan), 32'd0);
        cmp("reset:rdy", 32'(m_rdy), 32'd0);

        // Small instance: channels 0..3 on edges 5..8.
        s_por = 1'b0; s_dd = 1'b1; s_rst_n = 1'b1;
        cyc(3, "sweep");
        cmp("sweep:e3_state", 32'(s_state), 32'd1);
        cyc(1, "sweep");
        cmp("sweep:e4_state", 32'(s_state), 32'd2);
        cmp("sweep:e4_chan", 32'(s_chan), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, "sweep");
            cmp("sweep:chan_step", 32'(s_chan), (32'd1 << (k + 1)) - 32'd1);
        end
        cmp("sweep:e8_rdy", 32'(s_rdy), 32'd1);
        cmp("sweep:e8_state", 32'(s_state), 32'd3);

        // Nominal release on the default instance.
        m_por = 1'b0; m_dd = 1'b1; m_rst_n = 1'b1;
        cyc(17, "nominal");
        cmp("nominal:e17_state", 32'(m_state), 32'd1);
        cyc(1, "nominal");
        cmp("nominal:e18_state", 32'(m_state), 32'd2);
        cyc(3, "nominal");
        cmp("nominal:e21_ch0", 32'(m_chan[0]), 32'd0);
        cyc(1, "nominal");
        cmp("nominal:e22_ch0", 32'(m_chan[0]), 32'd1);
        cyc(91, "nominal");
        cmp("nominal:e113_rdy", 32'(m_rdy), 32'd0);
        cmp("nominal:e113_ch23", 32'(m_chan[23]), 32'd0);
        cyc(1, "nominal");
        cmp("nominal:e114_rdy", 32'(m_rdy), 32'd1);
        cmp("nominal:e114_chan", 32'(m_chan), 32'h00FF_FFFF);
        cmp("nominal:e114_state", 32'(m_state), 32'd3);

        // Debounce glitch after g qualified raw cycles.
        m_rst_n = 1'b0; m_por = 1'b1; m_dd = 1'b0;
        cyc(2, "glitch_rst");
        m_por = 1'b0; m_dd = 1'b1; m_rst_n = 1'b1;
        g = int'($urandom_range(15, 2));
        cyc(g, "glitch");
        m_dd = 1'b0;
        cyc(1, "glitch");
        m_dd = 1'b1;
        cyc(17, "glitch");
        cmp("glitch:pre_state", 32'(m_state), 32'd1);
        cmp("glitch:pre_chan", 32'(m_chan), 32'd0);
        cyc(1, "glitch");
        cmp("glitch:rel_state", 32'(m_state), 32'd2);

        // Abort one cycle after channel 5 releases; coincides with channel 6's slot.
        cyc(24, "abort_rel");
        cmp("abort_rel:ch5", 32'(m_chan[5]), 32'd1);
        cmp("abort_rel:ch6", 32'(m_chan[6]), 32'd0);
        cyc(1, "abort_rel");
        m_por = 1'b1;
        cyc(2, "abort_rel");
        cmp("abort_rel:still_ch5", 32'(m_chan[5]), 32'd1);
        cyc(1, "abort_rel");
        cmp("abort_rel:chan0", 32'(m_chan), 32'd0);
        cmp("abort_rel:state", 32'(m_state), 32'd1);
        m_por = 1'b0;
        cyc(17, "restart");
        cmp("restart:pre_state", 32'(m_state), 32'd1);
        cyc(1, "restart");
        cmp("restart:rel_state", 32'(m_state), 32'd2);
        cyc(4, "restart");
        cmp("restart:ch0", 32'(m_chan[0]), 32'd1);
        cmp("restart:ch1", 32'(m_chan[1]), 32'd0);

        // Abort from READY via device detect.
        cyc(92, "abort_rdy");
        cmp("abort_rdy:rdy", 32'(m_rdy), 32'd1);
        h = int'($urandom_range(5, 0));
        cyc(h, "abort_rdy");
        m_dd = 1'b0;
        cyc(2, "abort_rdy");
        cmp("abort_rdy:rdy_held", 32'(m_rdy), 32'd1);
        cyc(1, "abort_rdy");
        cmp("abort_rdy:rdy_drop", 32'(m_rdy), 32'd0);
        cmp("abort_rdy:chan_drop", 32'(m_chan), 32'd0);

        // Asynchronous reset between edges while releasing.
        m_dd = 1'b1;
        cyc(28, "async");
        cmp("async:pre_state", 32'(m_state), 32'd2);
        #2;
        m_rst_n = 1'b0;
        #1;
        cmp("async:state", 32'(m_state), 32'd0);
        cmp("async:chan", 32'(m_chan), 32'd0);
        cmp("async:rdy", 32'(m_rdy), 32'd0);
        check_models("async");
        cyc(2, "async");

        // Random segments on both instances.
        m_por = 1'b0; m_dd = 1'b1; m_rst_n = 1'b1;
        for (int seg = 0; seg < 14; seg++) begin
            if ($urandom_range(99) < 65) begin
                m_por = 1'b0; m_dd = 1'b1;
            end else begin
                m_por = 1'($urandom_range(1)); m_dd = 1'($urandom_range(1));
            end
            if ($urandom_range(99) < 65) begin
                s_por = 1'b0; s_dd = 1'b1;
            end else begin
                s_por = 1'($urandom_range(1)); s_dd = 1'($urandom_range(1));
            end
            cyc(int'($urandom_range(140, 1)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aibcr3aux_por_seq.md
# aibcr3aux_por_seq

Power-on/device-detect reset sequencer sitting directly downstream of the master AUX block. It consumes the AUX POR output (`o_por_vcchssi`), the device-detect pad level and the AUX pass-through oscillator clock. It synchronizes and debounces them, then releases per-channel resets to the channel array one channel at a time. The staggered release limits supply in-rush at channel wake-up, and `o_aux_rdy` signals that every channel is out of reset.

## Interface
Parameters:
- `NCH`, 24, number of channel resets driven.
- `DEB_CYC`, 16, consecutive qualified cycles required before release starts; legal range 2..255.
- `STAGGER_CYC`, 4, cycles between successive channel releases; legal range 1..255.

Ports:
- `i_osc_clk`, input, 1: oscillator clock taken from AUX `osc_clkout`. Single clock domain for the whole block.
- `i_rst_n`, input, 1: reset, asynchronous assert, active-low.
- `i_por_vcchssi`, input, 1: AUX POR output, asynchronous to `i_osc_clk`. 1 means power not good.
- `i_device_detect`, input, 1: device-detect pad level, asynchronous to `i_osc_clk`. 1 means a partner is present.
- `o_chan_rst_n`, output, NCH: per-channel reset, active-low, registered.
- `o_aux_rdy`, output, 1: all channels released, registered.
- `o_seq_state`, output, 2: FSM state for debug. 00 IDLE, 01 WAIT_PWR, 10 RELEASE, 11 READY.

## Operation
- **Input synchronization:** `i_por_vcchssi` and `i_device_detect` each pass through a 2-flop synchronizer, giving `por_s` and `dd_s`. The synchronizer flops reset to por_s=1 and dd_s=0.
- **Qualification:** `qual = !por_s & dd_s`.
- **Debounce counter** (8 bit):
  - Increments on each qualified cycle.
  - Clears to 0 on any cycle with `!qual`.
  - Saturates at DEB_CYC-1.
- **FSM:**
  - IDLE: the reset state. Goes unconditionally to WAIT_PWR on the first edge after `i_rst_n` deasserts.
  - WAIT_PWR: all `o_chan_rst_n` = 0. Goes to RELEASE when `qual` is 1 and the counter equals DEB_CYC-1. On entering RELEASE, clear the channel index `idx` and the stagger counter `scnt`.
  - RELEASE: `scnt` increments every cycle. When `scnt` = STAGGER_CYC-1:
    - set `o_chan_rst_n[idx]` = 1 on the next edge;
    - `idx` = `idx`+1 and `scnt` = 0.
    - When `idx` = NCH-1 releases, go to READY on the same edge.
  - READY: `o_aux_rdy` = 1 and all `o_chan_rst_n` = 1. Hold until abort.
- **Abort:** in WAIT_PWR, RELEASE or READY, any cycle with `!qual` causes all of the following on the next edge:
  - `o_chan_rst_n` = 0;
  - `o_aux_rdy` = 0;
  - state goes to WAIT_PWR;
  - debounce counter, `idx` and `scnt` clear.
- **Debounce asymmetry:** the fall of `dd_s` and the rise of `por_s` are not debounced. Only release is filtered.
- **Ordering:** channels release in ascending index order. At most one bit of `o_chan_rst_n` changes 0→1 per edge. Released bits never return to 0 except through abort or `i_rst_n`.
- **Counter widths:**
  - `idx` is ceil(log2(NCH)) bits; `scnt` is 8 bits.
  - No wrap-around may occur. `idx` never exceeds NCH-1, and `scnt` never exceeds STAGGER_CYC-1.

## Timing
- **Reset values** (`i_rst_n` low, asynchronous):
  - `o_chan_rst_n` = all 0;
  - `o_aux_rdy` = 0;
  - `o_seq_state` = 00;
  - all counters 0.
- **Reset mid-operation:** asserting `i_rst_n` forces the reset values immediately, in any state.
- **Synchronizer latency:** 2 edges from an input change to `por_s`/`dd_s`.
- **Release latency:** with inputs qualified and stable before edge 1, RELEASE is entered at edge 2+DEB_CYC.
- **Channel release time:** channel k's reset rises STAGGER_CYC*(k+1) edges after RELEASE entry. `o_aux_rdy` rises on the same edge as channel NCH-1.
- **Abort latency:** 3 edges from an input violation to `o_chan_rst_n` all 0 (2 sync + 1 register).
- **Simultaneous events:** abort beats release on the same edge. If `!qual` coincides with `scnt` = STAGGER_CYC-1, the channel is not released.
- **STAGGER_CYC=1:** one channel releases per cycle.

## Test plan
1. **Nominal release** (defaults): hold `i_rst_n` low; then raise `i_rst_n`, hold por=0 and dd=1.
   - Expected: state 10 at edge 18; `o_chan_rst_n[0]` rises at edge 22 and `[23]` at edge 114; `o_aux_rdy` = 1 at edge 114.
2. **Debounce glitch:** qualified for 10 cycles, dd low for 1 cycle, then qualified.
   - Expected: the counter restarts; RELEASE is entered 16 qualified synchronized cycles after the glitch clears, and no channel releases early.
3. **Abort mid-release:** por rises 1 cycle after `o_chan_rst_n[5]` rises.
   - Expected: all `o_chan_rst_n` = 0 and state 01 within 3 edges.
   - When por falls again, the full sequence restarts with channel 0 and a fresh 16-cycle debounce.
4. **Abort in READY:** dd falls.
   - Expected: `o_aux_rdy` and all `o_chan_rst_n` drop 3 edges later.
5. **Async reset in RELEASE:** assert `i_rst_n` between clock edges.
   - Expected: outputs go to reset values without a clock edge; state 00.
6. **Parameter sweep** (NCH=4, DEB_CYC=2, STAGGER_CYC=1).
   - Expected: channels 0..3 release on consecutive edges starting at edge 5; `o_aux_rdy` at edge 8.
